// File: rtl/axi_b_resp_gen.sv
// Slave-side AXI write-response generator: queues AW requests, counts W beats per burst
// and issues one B response per burst (OKAY when WLAST lines up with AWLEN, else SLVERR).
module axi_b_resp_gen #(
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 6,
    parameter int AW_DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  aw_valid_i,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [USER_WIDTH-1:0] aw_user_i,
    input  logic [7:0]            aw_len_i,
    output logic                  aw_ready_o,
    input  logic                  w_valid_i,
    input  logic                  w_last_i,
    output logic                  w_ready_o,
    output logic                  b_valid_o,
    output logic [1:0]            b_resp_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [USER_WIDTH-1:0] b_user_o,
    input  logic                  b_ready_i
);
    localparam int PW = $clog2(AW_DEPTH);
    localparam int CW = PW + 1;

    logic [ID_WIDTH-1:0]   id_mem   [AW_DEPTH];
    logic [USER_WIDTH-1:0] user_mem [AW_DEPTH];
    logic [7:0]            len_mem  [AW_DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  b_valid_q, b_valid_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
    logic [USER_WIDTH-1:0] b_user_q, b_user_d;

    logic                  full, empty, push, w_hs, term, at_len;
    logic [ID_WIDTH-1:0]   head_id;
    logic [USER_WIDTH-1:0] head_user;
    logic [7:0]            head_len;

    assign full  = (cnt_q == CW'(AW_DEPTH));
    assign empty = (cnt_q == '0);

    // Readies are gated by reset so nothing handshakes while the block is held in reset.
    assign aw_ready_o = !full && !rst_i;
    assign w_ready_o  = !empty && (!b_valid_q || b_ready_i) && !rst_i;

    assign push      = aw_valid_i && aw_ready_o;
    assign w_hs      = w_valid_i && w_ready_o;
    assign head_id   = id_mem[rd_ptr_q];
    assign head_user = user_mem[rd_ptr_q];
    assign head_len  = len_mem[rd_ptr_q];
    assign at_len    = (beat_cnt_q == head_len);
    assign term      = w_hs && (w_last_i || at_len);

    generate
        for (genvar gi = 0; gi < AW_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    id_mem[gi]   <= aw_id_i;
                    user_mem[gi] <= aw_user_i;
                    len_mem[gi]  <= aw_len_i;
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        beat_cnt_d = beat_cnt_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        b_id_d     = b_id_q;
        b_user_d   = b_user_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (term) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !term) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && term) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (term) begin
            beat_cnt_d = '0;
        end else if (w_hs) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        // A reload wins over a drain, so back-to-back responses leave no bubble.
        if (term) begin
            b_valid_d = 1'b1;
            b_id_d    = head_id;
            b_user_d  = head_user;
            b_resp_d  = (w_last_i && at_len) ? 2'b00 : 2'b10;
        end else if (b_ready_i) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            beat_cnt_q <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
            b_id_q     <= '0;
            b_user_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            beat_cnt_q <= beat_cnt_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            b_id_q     <= b_id_d;
            b_user_q   <= b_user_d;
        end
    end

    assign b_valid_o = b_valid_q;
    assign b_resp_o  = b_resp_q;
    assign b_id_o    = b_id_q;
    assign b_user_o  = b_user_q;

endmodule

// File: tb/tb_axi_b_resp_gen.sv
// Bench for axi_b_resp_gen: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a queue-based burst model.
module tb_axi_b_resp_gen;
    localparam int IDW = 4;
    localparam int UW  = 6;
    localparam int DEP = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           aw_valid = 1'b0;
    logic [IDW-1:0] aw_id = '0;
    logic [UW-1:0]  aw_user = '0;
    logic [7:0]     aw_len = '0;
    logic           aw_ready;
    logic           w_valid = 1'b0;
    logic           w_last = 1'b0;
    logic           w_ready;
    logic           b_valid;
    logic [1:0]     b_resp;
    logic [IDW-1:0] b_id;
    logic [UW-1:0]  b_user;
    logic           b_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    axi_b_resp_gen #(.ID_WIDTH(IDW), .USER_WIDTH(UW), .AW_DEPTH(DEP)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_id_i(aw_id), .aw_user_i(aw_user), .aw_len_i(aw_len),
        .aw_ready_o(aw_ready),
        .w_valid_i(w_valid), .w_last_i(w_last), .w_ready_o(w_ready),
        .b_valid_o(b_valid), .b_resp_o(b_resp), .b_id_o(b_id), .b_user_o(b_user),
        .b_ready_i(b_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [IDW-1:0] id;
        logic [UW-1:0]  user;
        int             len;
    } aw_t;

    aw_t            m_q[$];
    int             m_beats = 0;
    logic           m_bv = 1'b0;
    logic [1:0]     m_bresp = 2'b00;
    logic [IDW-1:0] m_bid = '0;
    logic [UW-1:0]  m_buser = '0;

    function automatic logic exp_aw_ready();
        return m_q.size() < DEP;
    endfunction

    function automatic logic exp_w_ready();
        return (m_q.size() > 0) && (!m_bv || b_ready);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_beats = 0;
                m_bv = 1'b0;
            end else begin
                logic aw_hs, w_hs, done;
                aw_t  e;
                aw_hs = aw_valid && exp_aw_ready();
                w_hs  = w_valid && exp_w_ready();
                done  = 1'b0;
                if (w_hs) begin
                    e = m_q[0];
                    if (w_last || m_beats == e.len) begin
                        done    = 1'b1;
                        m_bresp = (w_last && m_beats == e.len) ? 2'b00 : 2'b10;
                        m_bid   = e.id;
                        m_buser = e.user;
                        void'(m_q.pop_front());
                        m_beats = 0;
                    end else begin
                        m_beats++;
                    end
                end
                if (done) m_bv = 1'b1;
                else if (b_ready) m_bv = 1'b0;
                if (aw_hs) begin
                    e.id = aw_id; e.user = aw_user; e.len = int'(aw_len);
                    m_q.push_back(e);
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_aw_ready", {31'b0, aw_ready}, 0);
                chk("rst_w_ready", {31'b0, w_ready}, 0);
                chk("rst_b_valid", {31'b0, b_valid}, 0);
                chk("rst_b_fields", {20'b0, b_resp, b_id, b_user}, 0);
            end else begin
                chk("aw_ready", {31'b0, aw_ready}, {31'b0, exp_aw_ready()});
                chk("w_ready", {31'b0, w_ready}, {31'b0, exp_w_ready()});
                chk("b_valid", {31'b0, b_valid}, {31'b0, m_bv});
                if (m_bv) begin
                    chk("b_id", {28'b0, b_id}, {28'b0, m_bid});
                    chk("b_user", {26'b0, b_user}, {26'b0, m_buser});
                    chk("b_resp", {30'b0, b_resp}, {30'b0, m_bresp});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_aw(input int id, input int user, input int len);
        bit ok = 0;
        aw_valid = 1'b1; aw_id = IDW'(id); aw_user = UW'(user); aw_len = 8'(len);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (aw_ready) begin
                @(posedge clk); #1;
                ok = 1;
            end
        end
        aw_valid = 1'b0;
        if (!ok) chk("aw_timeout", 1, 0);
        $display("AW id=%0d user=%0h len=%0d", id, user, len);
    endtask

    task automatic do_w(input logic last);
        bit ok = 0;
        w_valid = 1'b1; w_last = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (w_ready) begin
                @(posedge clk); #1;
                ok = 1;
            end
        end
        w_valid = 1'b0; w_last = 1'b0;
        if (!ok) chk("w_timeout", 1, 0);
        $display("W last=%0d", last);
    endtask

    task automatic chk_b(input string name, input int id, input int resp);
        chk({name, "_valid"}, {31'b0, b_valid}, 1);
        chk({name, "_id"}, {28'b0, b_id}, 32'(id));
        chk({name, "_resp"}, {30'b0, b_resp}, 32'(resp));
        $display("B %s id=%0d resp=%0d", name, b_id, b_resp);
    endtask

    initial begin
        #12;
        chk("init_b_valid", {31'b0, b_valid}, 0);
        chk("init_aw_ready", {31'b0, aw_ready}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_aw_ready", {31'b0, aw_ready}, 1);

        // Normal burst
        do_aw(3, 'h15, 3);
        do_w(0); do_w(0); do_w(0); do_w(1);
        chk_b("normal", 3, 0);
        chk("normal_user", {26'b0, b_user}, 'h15);
        @(posedge clk); #1;
        chk("normal_one_cycle", {31'b0, b_valid}, 0);

        // Early WLAST, then a len=0 burst
        do_aw(1, 0, 3);
        do_aw(2, 0, 0);
        do_w(0); do_w(1);
        chk_b("early", 1, 2);
        do_w(1);
        chk_b("after_early", 2, 0);

        // Missing WLAST
        do_aw(5, 0, 1);
        do_w(0); do_w(0);
        chk_b("missing", 5, 2);
        chk("missing_empty_w_ready", {31'b0, w_ready}, 0);

        // Full queue and back-pressure
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) do_aw(i, i, 0);
        aw_valid = 1'b1; aw_id = 4'd4; aw_len = 8'd0;
        @(negedge clk);
        chk("full_aw_ready", {31'b0, aw_ready}, 0);
        aw_valid = 1'b0;
        @(posedge clk); #1;
        b_ready = 1'b0;
        do_w(1);
        chk_b("bp", 0, 0);
        chk("bp_aw_ready", {31'b0, aw_ready}, 1);
        chk("bp_w_ready", {31'b0, w_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_b("bp_hold", 0, 0);
        b_ready = 1'b1;
        #1;
        chk("bp_w_reenable", {31'b0, w_ready}, 1);
        @(posedge clk); #1;
        chk("bp_drained", {31'b0, b_valid}, 0);
        do_w(1); do_w(1); do_w(1);

        // Back-to-back len=0 bursts
        @(posedge clk); #1;
        do_aw(7, 0, 0); do_aw(8, 0, 0); do_aw(9, 0, 0);
        w_valid = 1'b1; w_last = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            @(posedge clk); #1;
            chk_b("b2b", i, 0);
        end
        w_valid = 1'b0; w_last = 1'b0;

        // Mid-burst reset
        @(posedge clk); #1;
        do_aw(4, 0, 3);
        do_w(0); do_w(0);
        #2 rst = 1'b1;
        #1;
        chk("mrst_b_valid", {31'b0, b_valid}, 0);
        chk("mrst_aw_ready", {31'b0, aw_ready}, 0);
        chk("mrst_w_ready", {31'b0, w_ready}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("mrst_after_aw_ready", {31'b0, aw_ready}, 1);
        chk("mrst_after_w_ready", {31'b0, w_ready}, 0);
        do_aw(6, 1, 0);
        do_w(1);
        chk_b("mrst_fresh", 6, 0);

        // Random traffic, checked by the model each cycle
        for (int c = 0; c < 3000; c++) begin
            aw_valid = ($urandom_range(0, 1) == 1);
            aw_id    = IDW'($urandom);
            aw_user  = UW'($urandom);
            aw_len   = 8'($urandom_range(0, 3));
            w_valid  = ($urandom_range(0, 3) != 0);
            w_last   = ($urandom_range(0, 2) == 0);
            b_ready  = ($urandom_range(0, 3) != 0);
            if (c == 1500) rst = 1'b1;
            if (c == 1503) rst = 1'b0;
            @(posedge clk); #1;
        end
        aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_b_resp_gen.md
Name: axi_b_resp_gen

Overview:
Slave-side AXI write-response generator. It is the producer end of the B channel, feeding the B-channel buffer toward the master. It queues accepted AW requests and counts W beats against each burst's length. At the end of each burst it issues one B response carrying that burst's ID/USER, with OKAY or SLVERR depending on beat-count/WLAST consistency.

Parameters:
ID_WIDTH, 4, width of AW/B ID field
USER_WIDTH, 6, width of AW/B USER field
AW_DEPTH, 4, number of outstanding AW entries queued; power of 2, >=2

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
aw_valid_i  in  1  AW request valid
aw_id_i  in  ID_WIDTH  AW ID
aw_user_i  in  USER_WIDTH  AW USER
aw_len_i  in  8  AXI AWLEN (beats-1)
aw_ready_o  out  1  AW accepted
w_valid_i  in  1  W beat valid
w_last_i  in  1  W beat WLAST
w_ready_o  out  1  W beat accepted
b_valid_o  out  1  B response valid
b_resp_o  out  2  B response code
b_id_o  out  ID_WIDTH  B ID
b_user_o  out  USER_WIDTH  B USER
b_ready_i  in  1  B response accepted

Behaviour:
- Interface decided: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset (rst_i high, async): AW queue emptied, pointers/count=0, beat_cnt=0, B slot cleared. b_valid_o=0, b_resp_o=0, b_id_o=0, b_user_o=0. aw_ready_o and w_ready_o are forced 0 while rst_i is high. Reset mid-burst discards all queued AWs, the partial beat count, and any pending B.
- AW queue: circular FIFO of {id,user,len}, AW_DEPTH entries, occupancy counter of width $clog2(AW_DEPTH)+1.
  - aw_ready_o = !full. No fall-through: when full, aw_ready_o=0 even if a pop occurs in the same cycle.
  - Push on aw_valid_i & aw_ready_o. Simultaneous push and pop leave the count unchanged. Pointers wrap modulo AW_DEPTH.
- W acceptance: w_ready_o = !empty & (!b_valid_o | b_ready_i).
  - No AW bypass: the earliest W beat for a burst is accepted the cycle after its AW handshake.
  - W beats arriving before their AW stall (w_ready_o=0).
- Beat counter beat_cnt (8 bit) counts accepted beats of the head burst.
- Burst termination occurs on an accepted beat where w_last_i=1 OR beat_cnt==head.len. On termination:
  - pop the head entry and set beat_cnt<=0;
  - load the B slot with b_id_o=head.id and b_user_o=head.user;
  - b_resp_o=2'b00 (OKAY) if w_last_i=1 and beat_cnt==head.len, else 2'b10 (SLVERR).
- Non-terminating beat: beat_cnt<=beat_cnt+1. The counter never wraps, because termination is forced at len.
- Error cases:
  - Early WLAST gives SLVERR; the burst closes and the next beat belongs to the next AW.
  - A missing WLAST on beat len+1 gives SLVERR; the burst closes at that beat.
- B slot (single register):
  - b_valid_o rises the cycle after the terminating W handshake (latency 1).
  - Cleared on b_ready_i unless reloaded in the same cycle. A simultaneous drain and reload keeps b_valid_o=1 with the new contents.
  - While b_valid_o & !b_ready_i, all b_* outputs are held stable.
- Ordering: B responses are issued strictly in AW acceptance order; IDs are not reordered.
- Throughput: with b_ready_i=1 held, one W beat per cycle is sustained, including back-to-back bursts and len=0 bursts.

Test Plan:
- Normal burst:
  - Stimulus: AW id=3, user=0x15, len=3; then 4 W beats, WLAST on beat 4; b_ready_i=1.
  - Required: b_valid_o=1 for one cycle, the cycle after beat 4; b_id_o=3, b_user_o=0x15, b_resp_o=2'b00.
- Early WLAST:
  - Stimulus: AW id=1, len=3; WLAST on beat 2. Then AW id=2, len=0; one W beat with WLAST.
  - Required: first B is id=1, resp=2'b10. Second B is id=2, resp=2'b00.
- Missing WLAST:
  - Stimulus: AW id=5, len=1; 2 beats with w_last_i=0.
  - Required: B id=5, resp=2'b10 after beat 2; beat_cnt returns to 0 and the queue is empty.
- Full queue and back-pressure:
  - Stimulus: 4 AWs (ids 0..3) with no W, then a 5th AW.
  - Required: aw_ready_o=0 for the 5th AW.
  - Stimulus: then complete burst 0 (len=0) with b_ready_i=0.
  - Required: B id=0 is held stable; w_ready_o=0; aw_ready_o=1 the cycle after the pop. Raising b_ready_i drains id=0 and re-enables W.
- Back-to-back len=0 bursts:
  - Stimulus: ids 7,8,9 queued; W valid continuously with WLAST each beat; b_ready_i=1.
  - Required: three consecutive B cycles, ids 7,8,9, all resp=2'b00, no bubbles.
- Mid-burst reset:
  - Stimulus: assert rst_i asynchronously after beat 2 of a len=3 burst.
  - Required: b_valid_o=0, aw_ready_o=0, w_ready_o=0 immediately. After release, aw_ready_o=1 and a fresh len=0 burst returns OKAY.
